ysyx_210978_div_r2: RTL and testbench

Sequential radix-2 restoring divider serving the MDU's divide path (DIV/DIVU/REM/REMU and the W variants). Accepts one operand pair per transaction over a valid/ready handshake. Iterates one quotient bit per cycle and returns quotient and remainder together with a one-cycle `out_valid` pulse. Implements RISC-V divide-by-zero and signed-overflow results directly, without iterating.

---
 rtl/ysyx_210978_div_r2.sv | 128 ++++++++++++
 tb/tb_ysyx_210978_div_r2.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210978_div_r2.sv
// Sequential radix-2 restoring divider for the MDU divide path.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module ysyx_210978_div_r2 (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic        divw,
  input  logic        div_signed,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        out_ready,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cnt;
  logic [63:0] dvs;
  logic        is_w, q_neg, r_neg;

  logic [63:0] a_ext, b_ext, a_sx, a_mag, b_mag;
  logic        a_sign, b_sign, b_zero, ovf, accept, last_iter;
  logic [64:0] sh, diff;
  logic        borrow;
  logic [63:0] q_fix, r_fix, q_res, r_res;

  assign out_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & out_ready & ~flush;
  assign last_iter = (cnt == (is_w ? 7'd31 : 7'd63));

  // Operand prep: extend low W bits, take magnitudes, detect special cases.
  always_comb begin
    a_ext  = divw ? (div_signed ? {{32{dividend[31]}}, dividend[31:0]} : {32'b0, dividend[31:0]}) : dividend;
    b_ext  = divw ? (div_signed ? {{32{divisor[31]}},  divisor[31:0]}  : {32'b0, divisor[31:0]})  : divisor;
    a_sx   = divw ? {{32{dividend[31]}}, dividend[31:0]} : dividend;
    a_sign = div_signed & a_ext[63];
    b_sign = div_signed & b_ext[63];
    a_mag  = a_sign ? -a_ext : a_ext;
    b_mag  = b_sign ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    ovf    = div_signed & (b_ext == '1) &
             (a_ext == (divw ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
  end

  // Trial subtraction of one iteration; the 65th bit of the difference is the borrow.
  always_comb begin
    sh     = {remainder, quotient[63]};
    diff   = sh - {1'b0, dvs};
    borrow = diff[64];
  end

  // Sign fix-up and W-mode sign extension of the final result.
  always_comb begin
    q_fix = q_neg ? -quotient  : quotient;
    r_fix = r_neg ? -remainder : remainder;
    q_res = is_w ? {{32{q_fix[31]}}, q_fix[31:0]} : q_fix;
    r_res = is_w ? {{32{r_fix[31]}}, r_fix[31:0]} : r_fix;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (b_zero | ovf) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath. quotient/remainder double as the working {rem,quo} shift pair;
  // in W mode the dividend sits in the top half so 32 shifts consume it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      dvs       <= '0;
      is_w      <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (in_valid) begin
          cnt   <= '0;
          is_w  <= divw;
          q_neg <= a_sign ^ b_sign;
          r_neg <= a_sign;
          dvs   <= divw ? {32'b0, b_mag[31:0]} : b_mag;
          if (b_zero) begin
            quotient  <= '1;
            remainder <= a_sx;
          end else if (ovf) begin
            quotient  <= a_sx;
            remainder <= '0;
          end else begin
            quotient  <= divw ? {a_mag[31:0], 32'b0} : a_mag;
            remainder <= '0;
          end
        end
        CALC: begin
          cnt       <= cnt + 7'd1;
          quotient  <= {quotient[62:0], ~borrow};
          remainder <= borrow ? sh[63:0] : diff[63:0];
        end
        FIX: begin
          quotient  <= q_res;
          remainder <= r_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_210978_div_r2.sv
module tb_ysyx_210978_div_r2;

  logic        clock, reset, flush, in_valid, divw, div_signed;
  logic [63:0] dividend, divisor;
  logic        out_ready, out_valid;
  logic [63:0] quotient, remainder;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  ysyx_210978_div_r2 dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .divw      (divw),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic w, input logic s, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output int lat);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    q32 = '0;
    r32 = '0;
    if (w) begin
      lat = 33;
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; lat = 0; end
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; lat = 0; end
      else if (s) begin
        q32 = 32'($signed(a32) / $signed(b32));
        r32 = 32'($signed(a32) % $signed(b32));
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      lat = 65;
      if (b == 64'd0) begin q = '1; r = a; lat = 0; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; lat = 0; end
      else if (s) begin
        q = 64'($signed(a) / $signed(b));
        r = 64'($signed(a) % $signed(b));
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  // One transaction: drive at negedge, push expectation, wait (bounded) for the pulse.
  task automatic run_op(input string tag, input logic w, input logic s, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                        input int el);
    exp_t e, got;
    int   lat;
    @(negedge clock);
    chk({tag, "_ready"}, 64'(out_ready), 64'd1);
    in_valid = 1'b1; divw = w; div_signed = s; dividend = a; divisor = b;
    e.q = eq; e.r = er; e.lat = el;
    sb.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0; divw = ~w; div_signed = ~s; dividend = ~a; divisor = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    got = sb.pop_front();
    chk({tag, "_lat"}, 64'(lat), 64'(got.lat));
    chk({tag, "_quo"}, quotient, got.q);
    chk({tag, "_rem"}, remainder, got.r);
    chk({tag, "_busy"}, 64'(out_ready), 64'd0);
    @(posedge clock); #1;
    chk({tag, "_pulse"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(out_ready), 64'd1);
  endtask

  task automatic rand_op(input string tag);
    logic        w, s;
    logic [63:0] a, b, q, r;
    int          lat;
    w = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    a = {$urandom, $urandom};
    b = {$urandom, $urandom} >> $urandom_range(0, 63);
    if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(1, 1000));
    model(w, s, a, b, q, r, lat);
    run_op(tag, w, s, a, b, q, r, lat);
  endtask

  initial begin
    int seen;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(out_ready), 64'd1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_quo", quotient, 64'd0);
    chk("rst_rem", remainder, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("u100_7",  1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    run_op("sm7_2",   1'b0, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("s7_m2",   1'b0, 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_op("sm8_m3",  1'b0, 1'b1, -64'sd8, -64'sd3, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_op("dz64",    1'b0, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    run_op("dzw",     1'b1, 1'b0, 64'h1_0000_0003, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
    run_op("ovf64",   1'b0, 1'b1, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 0);
    run_op("ovfw",    1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_op("uw_sext", 1'b1, 1'b0, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 64'd0, 33);
    run_op("sw_m9_4", 1'b1, 1'b1, 64'hFFFF_FFF7, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    for (int i = 0; i < 8; i++) rand_op($sformatf("rnd%0d", i));

    // Flush ten cycles into a 64-bit operation.
    @(negedge clock);
    in_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock); #1;
    chk("flush_ready", 64'(out_ready), 64'd1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    seen = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1;
    end
    chk("flush_nopulse", 64'(seen), 64'd0);

    // Flush wins over a simultaneous request.
    @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; dividend = 64'd9; divisor = 64'd0;
    @(posedge clock); #1;
    chk("flushpri_ready", 64'(out_ready), 64'd1);
    chk("flushpri_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;

    run_op("post_flush", 1'b0, 1'b0, 64'd20, 64'd3, 64'd6, 64'd2, 65);

    // Reset asserted mid-CALC.
    @(negedge clock);
    in_valid = 1'b1; divw = 1'b0; div_signed = 1'b1; dividend = 64'd12345; divisor = 64'd17;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_ready", 64'(out_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_quo", quotient, 64'd0);
    chk("midrst_rem", remainder, 64'd0);
    @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1;
    end
    chk("midrst_nopulse", 64'(seen), 64'd0);

    // in_valid held through DONE: no accept in DONE, re-accept at first IDLE edge.
    @(negedge clock);
    in_valid = 1'b1; divw = 1'b0; div_signed = 1'b0; dividend = 64'd9; divisor = 64'd0;
    @(posedge clock); #1;
    chk("hold_done1", 64'(out_valid), 64'd1);
    @(posedge clock); #1;
    chk("hold_idle_valid", 64'(out_valid), 64'd0);
    chk("hold_idle_ready", 64'(out_ready), 64'd1);
    @(posedge clock); #1;
    chk("hold_done2", 64'(out_valid), 64'd1);
    chk("hold_rem", remainder, 64'd9);
    in_valid = 1'b0;
    @(posedge clock); #1;

    rand_op("rnd_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
